// File: rtl/fft_memory_interface_if.sv
// APB slave bus plus engine sample-memory port of the FFT memory front end.
// The DUT uses the slave modport; the driving side (engine/APB host) uses master.
interface fft_memory_interface_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [DATA_W-1:0] pwdata_i;
    logic [DATA_W-1:0] prdata_o;
    logic              pready_o;

    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_write_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ready_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  mem_addr_i, mem_data_i, mem_write_i,
        output prdata_o, pready_o, mem_data_o, mem_ready_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output mem_addr_i, mem_data_i, mem_write_i,
        input  prdata_o, pready_o, mem_data_o, mem_ready_o
    );
endinterface

// File: rtl/fft_memory_interface.sv
// Sample RAM shared by FFT engine and APB, plus APB control/config/status registers.
// Latency: RAM and register reads are combinational; writes and control outputs update one edge later.
// Backpressure: none, pready_o is tied high; an engine write beats a same-cycle APB RAM write.
module fft_memory_interface #(
    parameter int MEM_DEPTH = 2048,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    fft_memory_interface_if.slave bus,

    output logic        fft_start_o,
    output logic        fft_reset_o,
    output logic        buffer_swap_o,
    output logic        buffer_sel_o,
    output logic [3:0]  fft_length_log2_o,
    output logic        rescale_en_o,
    output logic        scale_track_en_o,
    output logic        rescale_mode_o,
    output logic        rounding_mode_o,
    output logic        saturation_en_o,
    output logic        overflow_detect_o,
    output logic [7:0]  int_enable_o,

    input  logic        fft_busy_i,
    input  logic        fft_done_i,
    input  logic        fft_error_i,
    input  logic        buffer_active_i,
    input  logic        rescaling_active_i,
    input  logic        overflow_detected_i,
    input  logic [7:0]  scale_factor_i,
    input  logic [7:0]  stage_count_i,
    input  logic [7:0]  overflow_count_i,
    input  logic [7:0]  last_overflow_stage_i,
    input  logic [7:0]  max_overflow_magnitude_i,
    input  logic [7:0]  int_status_i
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 16'h0000;
    localparam logic [ADDR_W-1:0] ADDR_CONFIG = 16'h0004;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 16'h0008;
    localparam logic [ADDR_W-1:0] ADDR_INT_EN = 16'h000C;
    localparam logic [ADDR_W-1:0] ADDR_INTST  = 16'h0010;
    localparam logic [ADDR_W-1:0] ADDR_OVF    = 16'h0014;

    logic [DATA_W-1:0] ram_q [MEM_DEPTH];

    logic [3:0] ctrl_q,   ctrl_d;
    logic [9:0] config_q, config_d;
    logic [7:0] int_en_q, int_en_d;
    logic       mem_ready_q, mem_ready_d;

    logic              apb_wr;
    logic              apb_ram_sel;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              unused_addr_bits;

    assign apb_wr      = bus.psel_i & bus.penable_i & bus.pwrite_i;
    assign apb_ram_sel = (bus.paddr_i[ADDR_W-1:AW+2] == 1);
    assign unused_addr_bits = ^bus.mem_addr_i[ADDR_W-1:AW];

    // Single RAM write port: engine has priority, APB RAM write is dropped on collision
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = bus.mem_addr_i[AW-1:0];
        ram_wdata = bus.mem_data_i;
        if (bus.mem_write_i) begin
            ram_we = 1'b1;
        end else if (apb_wr && apb_ram_sel) begin
            ram_we    = 1'b1;
            ram_waddr = bus.paddr_i[AW+1:2];
            ram_wdata = bus.pwdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        config_d    = config_q;
        int_en_d    = int_en_q;
        mem_ready_d = 1'b1;
        if (apb_wr) begin
            case (bus.paddr_i)
                ADDR_CTRL:   ctrl_d   = bus.pwdata_i[3:0];
                ADDR_CONFIG: config_d = bus.pwdata_i[9:0];
                ADDR_INT_EN: int_en_d = bus.pwdata_i[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctrl_q      <= 4'h0;
            config_q    <= 10'h00A;
            int_en_q    <= 8'h00;
            mem_ready_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            config_q    <= config_d;
            int_en_q    <= int_en_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    always_comb begin
        bus.prdata_o = '0;
        if (bus.psel_i && !bus.pwrite_i) begin
            if (apb_ram_sel) begin
                bus.prdata_o = ram_q[bus.paddr_i[AW+1:2]];
            end else begin
                case (bus.paddr_i)
                    ADDR_CTRL:   bus.prdata_o = {28'h0, ctrl_q};
                    ADDR_CONFIG: bus.prdata_o = {22'h0, config_q};
                    ADDR_STATUS: bus.prdata_o = {8'h0, stage_count_i, scale_factor_i, 2'b00,
                                                 overflow_detected_i, rescaling_active_i,
                                                 buffer_active_i, fft_error_i, fft_done_i,
                                                 fft_busy_i};
                    ADDR_INT_EN: bus.prdata_o = {24'h0, int_en_q};
                    ADDR_INTST:  bus.prdata_o = {24'h0, int_status_i};
                    ADDR_OVF:    bus.prdata_o = {8'h0, max_overflow_magnitude_i,
                                                 last_overflow_stage_i, overflow_count_i};
                    default:     bus.prdata_o = '0;
                endcase
            end
        end
    end

    assign bus.pready_o    = 1'b1;
    assign bus.mem_data_o  = ram_q[bus.mem_addr_i[AW-1:0]];
    assign bus.mem_ready_o = mem_ready_q;

    assign fft_start_o       = ctrl_q[0];
    assign fft_reset_o       = ctrl_q[1];
    assign buffer_swap_o     = ctrl_q[2];
    assign buffer_sel_o      = ctrl_q[3];
    assign fft_length_log2_o = config_q[3:0];
    assign rescale_en_o      = config_q[4];
    assign scale_track_en_o  = config_q[5];
    assign rescale_mode_o    = config_q[6];
    assign rounding_mode_o   = config_q[7];
    assign saturation_en_o   = config_q[8];
    assign overflow_detect_o = config_q[9];
    assign int_enable_o      = int_en_q;
endmodule

// File: tb/tb_fft_memory_interface.sv
// Directed bench for fft_memory_interface: APB register/RAM access, engine port, collisions, reset.
module tb_fft_memory_interface;
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    fft_memory_interface_if #(.DATA_W(32), .ADDR_W(16)) bus ();

    logic       fft_start_o, fft_reset_o, buffer_swap_o, buffer_sel_o;
    logic [3:0] fft_length_log2_o;
    logic       rescale_en_o, scale_track_en_o, rescale_mode_o, rounding_mode_o;
    logic       saturation_en_o, overflow_detect_o;
    logic [7:0] int_enable_o;
    logic       fft_busy_i = 0, fft_done_i = 0, fft_error_i = 0;
    logic       buffer_active_i = 0, rescaling_active_i = 0, overflow_detected_i = 0;
    logic [7:0] scale_factor_i = 0, stage_count_i = 0, overflow_count_i = 0;
    logic [7:0] last_overflow_stage_i = 0, max_overflow_magnitude_i = 0, int_status_i = 0;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd;

    fft_memory_interface dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus),
        .fft_start_o(fft_start_o), .fft_reset_o(fft_reset_o),
        .buffer_swap_o(buffer_swap_o), .buffer_sel_o(buffer_sel_o),
        .fft_length_log2_o(fft_length_log2_o), .rescale_en_o(rescale_en_o),
        .scale_track_en_o(scale_track_en_o), .rescale_mode_o(rescale_mode_o),
        .rounding_mode_o(rounding_mode_o), .saturation_en_o(saturation_en_o),
        .overflow_detect_o(overflow_detect_o), .int_enable_o(int_enable_o),
        .fft_busy_i(fft_busy_i), .fft_done_i(fft_done_i), .fft_error_i(fft_error_i),
        .buffer_active_i(buffer_active_i), .rescaling_active_i(rescaling_active_i),
        .overflow_detected_i(overflow_detected_i), .scale_factor_i(scale_factor_i),
        .stage_count_i(stage_count_i), .overflow_count_i(overflow_count_i),
        .last_overflow_stage_i(last_overflow_stage_i),
        .max_overflow_magnitude_i(max_overflow_magnitude_i), .int_status_i(int_status_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ctrl_bits(output logic [31:0] v);
        v = {28'h0, buffer_sel_o, buffer_swap_o, fft_reset_o, fft_start_o};
    endtask

    task automatic cfg_bits(output logic [31:0] v);
        v = {22'h0, overflow_detect_o, saturation_en_o, rounding_mode_o, rescale_mode_o,
             scale_track_en_o, rescale_en_o, fft_length_log2_o};
    endtask

    // Setup phase on one negedge, access phase on the next, commit at the following posedge
    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.psel_i = 1; bus.pwrite_i = 1; bus.penable_i = 0; bus.paddr_i = a; bus.pwdata_i = d;
        @(negedge clk_i);
        bus.penable_i = 1;
        @(posedge clk_i); #1;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk_i);
        bus.psel_i = 1; bus.pwrite_i = 0; bus.penable_i = 1; bus.paddr_i = a;
        #1 d = bus.prdata_o;
        bus.psel_i = 0; bus.penable_i = 0;
    endtask

    task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.mem_write_i = 1; bus.mem_addr_i = a; bus.mem_data_i = d;
        @(posedge clk_i); #1;
        bus.mem_write_i = 0;
    endtask

    task automatic eng_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk_i);
        bus.mem_addr_i = a;
        #1 d = bus.mem_data_o;
    endtask

    initial begin
        logic [31:0] v;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = 0; bus.pwdata_i = 0;
        bus.mem_addr_i = 0; bus.mem_data_i = 0; bus.mem_write_i = 0;

        // Reset state
        #12;
        chk("rst_mem_ready", {31'h0, bus.mem_ready_o}, 32'h0);
        ctrl_bits(v); chk("rst_ctrl", v, 32'h0);
        cfg_bits(v);  chk("rst_config", v, 32'h00A);
        chk("rst_int_en", {24'h0, int_enable_o}, 32'h0);
        @(negedge clk_i); reset_n_i = 1;
        @(posedge clk_i); #1;
        chk("mem_ready_up", {31'h0, bus.mem_ready_o}, 32'h1);

        // Engine port write/read
        eng_write(16'h0000, 32'hA5A5A5A5);
        eng_write(16'h0001, 32'h5A5A5A5A);
        eng_read(16'h0000, rd); chk("eng_rd0", rd, 32'hA5A5A5A5);
        eng_read(16'h0001, rd); chk("eng_rd1", rd, 32'h5A5A5A5A);

        // CTRL start bit: changes only on the committing edge, then holds
        @(negedge clk_i);
        bus.psel_i = 1; bus.pwrite_i = 1; bus.penable_i = 0; bus.paddr_i = 16'h0000; bus.pwdata_i = 32'h1;
        @(negedge clk_i); bus.penable_i = 1;
        #1 chk("start_before_edge", {31'h0, fft_start_o}, 32'h0);
        @(posedge clk_i); #1;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
        chk("start_after_edge", {31'h0, fft_start_o}, 32'h1);
        repeat (3) @(posedge clk_i); #1;
        chk("start_holds", {31'h0, fft_start_o}, 32'h1);
        apb_read(16'h0000, rd); chk("ctrl_rd", rd, 32'h1);
        chk("pready", {31'h0, bus.pready_o}, 32'h1);

        // Top-of-RAM and address aliasing
        eng_write(16'h07FF, 32'hDEADBEEF);
        eng_read(16'h07FF, rd); chk("eng_rd7ff", rd, 32'hDEADBEEF);
        eng_write(16'h0800, 32'h12345678);
        eng_read(16'h0000, rd); chk("alias_rd0", rd, 32'h12345678);
        eng_read(16'hF800, rd); chk("alias_rdf800", rd, 32'h12345678);
        eng_read(16'h07FF, rd); chk("alias_7ff_kept", rd, 32'hDEADBEEF);

        apb_write(16'h0000, 32'h2);
        ctrl_bits(v); chk("ctrl_reset_bit", v, 32'h2);

        // Status registers
        apb_read(16'h0004, rd); chk("config_rst_rd", rd, 32'h0000000A);
        fft_busy_i = 1; stage_count_i = 8'h05;
        apb_read(16'h0008, rd); chk("status_rd", rd, 32'h00050001);
        fft_busy_i = 0; fft_done_i = 1; overflow_detected_i = 1; scale_factor_i = 8'hC3;
        apb_read(16'h0008, rd); chk("status_rd2", rd, 32'h0005C322);
        apb_read(16'h0100, rd); chk("unmapped_rd", rd, 32'h0);
        overflow_count_i = 8'h11; last_overflow_stage_i = 8'h22; max_overflow_magnitude_i = 8'h33;
        apb_read(16'h0014, rd); chk("ovf_rd", rd, 32'h00332211);
        int_status_i = 8'h5C;
        apb_read(16'h0010, rd); chk("intst_rd", rd, 32'h0000005C);

        // APB RAM window
        apb_write(16'h2004, 32'hCAFEF00D);
        eng_read(16'h0001, rd); chk("apb_ram_to_eng", rd, 32'hCAFEF00D);
        apb_read(16'h3FFC, rd); chk("apb_ram_rd7ff", rd, 32'hDEADBEEF);
        apb_read(16'h2004, rd); chk("apb_ram_rd1", rd, 32'hCAFEF00D);

        // Same-cycle collisions: engine wins, APB write lost even at a different address
        eng_write(16'h0006, 32'h60066006);
        @(negedge clk_i);
        bus.psel_i = 1; bus.pwrite_i = 1; bus.penable_i = 0; bus.paddr_i = 16'h2004; bus.pwdata_i = 32'h22222222;
        @(negedge clk_i);
        bus.penable_i = 1; bus.mem_write_i = 1; bus.mem_addr_i = 16'h0001; bus.mem_data_i = 32'h11111111;
        @(posedge clk_i); #1;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.mem_write_i = 0;
        eng_read(16'h0001, rd); chk("collide_same", rd, 32'h11111111);
        @(negedge clk_i);
        bus.psel_i = 1; bus.pwrite_i = 1; bus.penable_i = 0; bus.paddr_i = 16'h2018; bus.pwdata_i = 32'h66666666;
        @(negedge clk_i);
        bus.penable_i = 1; bus.mem_write_i = 1; bus.mem_addr_i = 16'h0005; bus.mem_data_i = 32'h55555555;
        @(posedge clk_i); #1;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.mem_write_i = 0;
        eng_read(16'h0005, rd); chk("collide_eng5", rd, 32'h55555555);
        eng_read(16'h0006, rd); chk("collide_apb6_dropped", rd, 32'h60066006);

        // Register widths, RO/unmapped write immunity
        apb_write(16'h0004, 32'hFFFFFFFF);
        apb_read(16'h0004, rd); chk("config_full_rd", rd, 32'h000003FF);
        cfg_bits(v); chk("config_outputs", v, 32'h3FF);
        apb_write(16'h000C, 32'hFFFFFF81);
        apb_read(16'h000C, rd); chk("int_en_rd", rd, 32'h00000081);
        chk("int_en_out", {24'h0, int_enable_o}, 32'h81);
        apb_write(16'h0100, 32'hFFFFFFFF);
        apb_read(16'h0100, rd); chk("unmapped_wr_ignored", rd, 32'h0);
        apb_write(16'h0008, 32'hFFFFFFFF);
        apb_read(16'h0008, rd); chk("status_wr_ignored", rd, 32'h0005C322);
        ctrl_bits(v); chk("ctrl_untouched", v, 32'h2);

        // prdata gating
        @(negedge clk_i);
        bus.psel_i = 0; bus.pwrite_i = 0; bus.paddr_i = 16'h0004;
        #1 chk("prdata_nosel", bus.prdata_o, 32'h0);
        bus.psel_i = 1; bus.pwrite_i = 1;
        #1 chk("prdata_write", bus.prdata_o, 32'h0);
        bus.psel_i = 0; bus.pwrite_i = 0;

        // Asynchronous reset mid-operation
        apb_write(16'h0000, 32'hF);
        @(posedge clk_i); #3;
        reset_n_i = 0;
        #1;
        ctrl_bits(v); chk("arst_ctrl", v, 32'h0);
        cfg_bits(v);  chk("arst_config", v, 32'h00A);
        chk("arst_int_en", {24'h0, int_enable_o}, 32'h0);
        chk("arst_mem_ready", {31'h0, bus.mem_ready_o}, 32'h0);
        eng_read(16'h07FF, rd); chk("arst_ram_kept", rd, 32'hDEADBEEF);
        @(negedge clk_i); reset_n_i = 1;
        @(posedge clk_i); #1;
        chk("arst_mem_ready_up", {31'h0, bus.mem_ready_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_memory_interface.md
Name: fft_memory_interface

Overview:
Register and sample-memory front end for the FFT core. It holds a 2048 x 32-bit sample RAM that the FFT engine reads and writes directly, and that software reaches through an APB window. It also provides an APB register file that drives FFT control/configuration outputs and exposes engine status. Everything runs on a single clock domain.

Parameters:
MEM_DEPTH, 2048, sample RAM depth in 32-bit words (address width = log2 = 11)
DATA_W, 32, RAM word and APB data width
ADDR_W, 16, mem_addr_i and paddr_i width

Ports:
clk_i in 1 sole clock (APB and engine side)
reset_n_i in 1 asynchronous active-low reset
psel_i in 1 APB select
penable_i in 1 APB enable
pwrite_i in 1 APB write
paddr_i in 16 APB byte address
pwdata_i in 32 APB write data
prdata_o out 32 APB read data
pready_o out 1 APB ready
mem_addr_i in 16 engine word address; only [10:0] used
mem_data_i in 32 engine write data
mem_write_i in 1 engine write strobe
mem_data_o out 32 engine read data
mem_ready_o out 1 memory ready
fft_start_o out 1 CTRL[0]
fft_reset_o out 1 CTRL[1]
buffer_swap_o out 1 CTRL[2]
buffer_sel_o out 1 CTRL[3]
fft_length_log2_o out 4 CONFIG[3:0]
rescale_en_o out 1 CONFIG[4]
scale_track_en_o out 1 CONFIG[5]
rescale_mode_o out 1 CONFIG[6]
rounding_mode_o out 1 CONFIG[7]
saturation_en_o out 1 CONFIG[8]
overflow_detect_o out 1 CONFIG[9]
int_enable_o out 8 INT_EN[7:0]
fft_busy_i, fft_done_i, fft_error_i, buffer_active_i, rescaling_active_i, overflow_detected_i in 1 each, engine status
scale_factor_i, stage_count_i, overflow_count_i, last_overflow_stage_i, max_overflow_magnitude_i, int_status_i in 8 each, engine status

Behaviour:
- Clock and reset: single clock clk_i; reset_n_i is asynchronous and active-low.
- Reset values: CTRL = 0; CONFIG = 0x00A (fft_length_log2_o = 10, all other CONFIG bits 0); INT_EN = 0; mem_ready_o = 0.
- mem_ready_o goes to 1 on the first clk_i edge after reset deasserts and stays at 1.
- RAM contents are not reset.
- Engine write: when mem_write_i = 1 at a clk_i posedge, RAM[mem_addr_i[10:0]] <= mem_data_i. mem_addr_i[15:11] is ignored, so addresses wrap modulo 2048.
- Engine read: mem_data_o = RAM[mem_addr_i[10:0]], combinational (asynchronous read, zero latency). A location written at edge N is visible on mem_data_o after edge N.
- APB protocol:
  - pready_o is tied to 1 (no wait states).
  - A write commits at the clk_i posedge where psel_i & penable_i & pwrite_i are all 1.
  - prdata_o is combinational from paddr_i while psel_i & !pwrite_i; otherwise it is 0.
- Register map (byte addresses):
  - 0x0000 CTRL, RW, bits [3:0]. Level bits, not self-clearing; software clears them.
  - 0x0004 CONFIG, RW, bits [9:0].
  - 0x0008 STATUS, RO: [0] busy, [1] done, [2] error, [3] buffer_active, [4] rescaling_active, [5] overflow_detected, [15:8] scale_factor, [23:16] stage_count.
  - 0x000C INT_EN, RW, bits [7:0].
  - 0x0010 INT_STATUS, RO: [7:0] = int_status_i.
  - 0x0014 OVF, RO: [7:0] overflow_count, [15:8] last_overflow_stage, [23:16] max_overflow_magnitude.
  - 0x2000–0x3FFC RAM window (paddr_i[15:13] = 3'b001): word index = paddr_i[12:2]. Reads return RAM contents combinationally; writes store pwdata_i.
- Unused register bits read 0. Unmapped addresses read 0 and ignore writes. Writes to RO registers are ignored.
- Write collision: the RAM has one write port. If an engine write and an APB RAM write occur in the same cycle, the engine write wins and the APB write is dropped (regardless of address).
- Reset asserted mid-operation clears the registers immediately; RAM contents are retained.
- Control outputs are driven directly from the register flops, so they change one edge after the APB write.

Test Plan:
- Engine writes 0xA5A5A5A5 to addr 0x0000 and 0x5A5A5A5A to 0x0001 -> reading each back gives mem_data_o = 0xA5A5A5A5 and 0x5A5A5A5A respectively.
- APB write 0x00000001 to 0x0000 -> fft_start_o = 1 on the next edge and it stays 1. APB read of 0x0000 -> prdata_o = 0x00000001, pready_o = 1.
- Engine write 0xDEADBEEF to 0x07FF -> mem_data_o = 0xDEADBEEF at 0x07FF. Write 0x12345678 to 0x0800 -> aliases to 0x0000.
- APB write 0x00000002 to 0x0000 -> fft_reset_o = 1, fft_start_o = 0.
- After reset, reading 0x0004 -> 0x0000000A. Drive fft_busy_i = 1 and stage_count_i = 0x05, then read 0x0008 -> 0x00050001. Read 0x0100 -> 0.
- APB write 0xCAFEF00D to 0x2004 -> engine read of addr 1 returns 0xCAFEF00D. Same-cycle engine write and APB RAM write to addr 1 -> engine data is stored.
